// File: rtl/countdown_timer.sv
// MM:SS countdown timer fed by the 1 Hz sec_tick; preset, start/pause/clear, alarm with auto-timeout.
// Optional build macro ALARM_BLINK_EN: alarm toggles on each sec_tick while in ALARM instead of holding steady.
module countdown_timer #(
  parameter int unsigned MAX_MIN    = 99,
  parameter int unsigned ALARM_SECS = 10
) (
  input  logic       mclk,
  input  logic       rst_n,
  input  logic       sec_tick,
  input  logic       btn_start,
  input  logic       btn_clear,
  input  logic       btn_min_inc,
  input  logic       btn_sec_inc,
  output logic [6:0] r_min,
  output logic [5:0] r_sec,
  output logic       run,
  output logic       alarm,
  output logic       done
);

  localparam int unsigned MIN_W = 7;
  localparam int unsigned SEC_W = 6;
  localparam int unsigned CNT_W = 8;

  localparam logic [MIN_W-1:0] MIN_TOP = MIN_W'(MAX_MIN);
  localparam logic [SEC_W-1:0] SEC_TOP = SEC_W'(59);
  localparam logic [CNT_W-1:0] CNT_TOP = CNT_W'(ALARM_SECS);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_PAUSE = 2'd2,
    S_ALARM = 2'd3
  } state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [MIN_W-1:0]   min_d;
  logic [SEC_W-1:0]   sec_d;
  logic               run_d, alarm_d, done_d;

  logic               nonzero_c;
  logic               last_sec_c;
  logic [CNT_W-1:0]   cnt_inc_c;

  assign nonzero_c  = (r_min != '0) || (r_sec != '0);
  assign last_sec_c = (r_min == '0) && (r_sec == SEC_W'(1));
  assign cnt_inc_c  = cnt_q + CNT_W'(1);

  // State and registered outputs
  always_ff @(posedge mclk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      r_min   <= '0;
      r_sec   <= '0;
      run     <= 1'b0;
      alarm   <= 1'b0;
      done    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      r_min   <= min_d;
      r_sec   <= sec_d;
      run     <= run_d;
      alarm   <= alarm_d;
      done    <= done_d;
    end
  end

  // Next state; clear beats everything, an expiring tick beats a pause request
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (!btn_clear && btn_start && nonzero_c) state_d = S_RUN;
      end
      S_RUN: begin
        if (btn_clear)                     state_d = S_IDLE;
        else if (sec_tick && last_sec_c)   state_d = S_ALARM;
        else if (btn_start)                state_d = S_PAUSE;
      end
      S_PAUSE: begin
        if (btn_clear)      state_d = S_IDLE;
        else if (btn_start) state_d = S_RUN;
      end
      S_ALARM: begin
        if (btn_clear || btn_start)                  state_d = S_IDLE;
        else if (sec_tick && (cnt_inc_c == CNT_TOP)) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Next values of the time registers and status outputs
  always_comb begin
    min_d   = r_min;
    sec_d   = r_sec;
    cnt_d   = cnt_q;
    run_d   = (state_d == S_RUN);
    alarm_d = 1'b0;
    done_d  = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (btn_clear) begin
          min_d = '0;
          sec_d = '0;
        end else if (state_d != S_RUN) begin
          if (btn_min_inc) min_d = (r_min == MIN_TOP) ? '0 : r_min + MIN_W'(1);
          if (btn_sec_inc) sec_d = (r_sec == SEC_TOP) ? '0 : r_sec + SEC_W'(1);
        end
      end
      S_RUN: begin
        if (btn_clear) begin
          min_d = '0;
          sec_d = '0;
        end else if (sec_tick) begin
          if (r_sec != '0) begin
            sec_d = r_sec - SEC_W'(1);
          end else begin
            min_d = r_min - MIN_W'(1);
            sec_d = SEC_TOP;
          end
        end
      end
      S_PAUSE: begin
        if (btn_clear) begin
          min_d = '0;
          sec_d = '0;
        end
      end
      S_ALARM: begin
        min_d = '0;
        sec_d = '0;
        if (sec_tick) cnt_d = cnt_inc_c;
      end
      default: begin
        min_d = '0;
        sec_d = '0;
      end
    endcase

    if (state_d != S_ALARM) begin
      cnt_d = '0;
    end else if (state_q != S_ALARM) begin
      cnt_d   = '0;
      alarm_d = 1'b1;
      done_d  = 1'b1;
    end else begin
`ifdef ALARM_BLINK_EN
      alarm_d = sec_tick ? ~alarm : alarm;
`else
      alarm_d = 1'b1;
`endif
    end
  end

endmodule

// File: tb/tb_countdown_timer.sv
// Self-checking bench for countdown_timer: per-cycle comparison against a seconds-based
// behavioural model, plus hand-computed literal checkpoints.
module tb_countdown_timer;

  localparam int MAX_MIN    = 99;
  localparam int ALARM_SECS = 10;
`ifdef ALARM_BLINK_EN
  localparam bit BLINK = 1'b1;
`else
  localparam bit BLINK = 1'b0;
`endif

  localparam logic [1:0] MD_IDLE  = 2'd0;
  localparam logic [1:0] MD_RUN   = 2'd1;
  localparam logic [1:0] MD_PAUSE = 2'd2;
  localparam logic [1:0] MD_ALARM = 2'd3;

  typedef struct packed {
    logic [1:0] mode;
    int         mn;
    int         sc;
    int         left;
    logic       alarm;
    logic       done;
  } mdl_t;

  logic       mclk = 1'b0;
  logic       rst_n = 1'b1;
  logic       sec_tick = 1'b0;
  logic       btn_start = 1'b0;
  logic       btn_clear = 1'b0;
  logic       btn_min_inc = 1'b0;
  logic       btn_sec_inc = 1'b0;
  logic [6:0] r_min;
  logic [5:0] r_sec;
  logic       run, alarm, done;

  mdl_t  mdl = '0;
  int    n_cmp = 0;
  int    n_fail = 0;
  logic  chk_en = 1'b0;
  logic  probe = 1'b0;
  logic  lit_req = 1'b0;
  string lit_nm = "";
  int    lit_min, lit_sec, lit_run, lit_alarm, lit_done;

  countdown_timer #(.MAX_MIN(MAX_MIN), .ALARM_SECS(ALARM_SECS)) dut (
    .mclk(mclk), .rst_n(rst_n), .sec_tick(sec_tick), .btn_start(btn_start),
    .btn_clear(btn_clear), .btn_min_inc(btn_min_inc), .btn_sec_inc(btn_sec_inc),
    .r_min(r_min), .r_sec(r_sec), .run(run), .alarm(alarm), .done(done)
  );

  always #5 mclk = ~mclk;

  // Reference behaviour: running time handled as a total number of seconds
  function automatic mdl_t model_step(input mdl_t m, input logic t, input logic s,
                                      input logic c, input logic mi, input logic si);
    mdl_t n = m;
    int   total;
    n.done = 1'b0;
    if (c) begin
      n.mode = MD_IDLE; n.mn = 0; n.sc = 0; n.left = 0; n.alarm = 1'b0;
      return n;
    end
    case (m.mode)
      MD_IDLE: begin
        if (s && (m.mn * 60 + m.sc) > 0) n.mode = MD_RUN;
        else begin
          if (mi) n.mn = (m.mn + 1) % (MAX_MIN + 1);
          if (si) n.sc = (m.sc + 1) % 60;
        end
      end
      MD_RUN: begin
        if (t) begin
          total = m.mn * 60 + m.sc - 1;
          n.mn = total / 60;
          n.sc = total % 60;
          if (total == 0) begin
            n.mode = MD_ALARM; n.left = ALARM_SECS; n.alarm = 1'b1; n.done = 1'b1;
            return n;
          end
        end
        if (s) n.mode = MD_PAUSE;
      end
      MD_PAUSE: if (s) n.mode = MD_RUN;
      default: begin
        if (s) begin
          n.mode = MD_IDLE; n.alarm = 1'b0;
        end else if (t) begin
          n.left = m.left - 1;
          if (n.left == 0) begin
            n.mode = MD_IDLE; n.alarm = 1'b0;
          end else begin
            n.alarm = BLINK ? !m.alarm : 1'b1;
          end
        end
      end
    endcase
    return n;
  endfunction

  always @(posedge mclk or negedge rst_n) begin
    if (!rst_n) mdl <= '0;
    else        mdl <= model_step(mdl, sec_tick, btn_start, btn_clear, btn_min_inc, btn_sec_inc);
  end

  task automatic cmp(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Single compare process: every cycle vs model, plus pending literal checkpoints
  always @(negedge mclk or posedge probe) begin
    if (chk_en) begin
      cmp("r_min", int'(r_min), mdl.mn);
      cmp("r_sec", int'(r_sec), mdl.sc);
      cmp("run",   int'(run),   int'(mdl.mode == MD_RUN));
      cmp("alarm", int'(alarm), int'(mdl.alarm));
      cmp("done",  int'(done),  int'(mdl.done));
      if (lit_req) begin
        cmp({lit_nm, ".r_min"}, int'(r_min), lit_min);
        cmp({lit_nm, ".r_sec"}, int'(r_sec), lit_sec);
        cmp({lit_nm, ".run"},   int'(run),   lit_run);
        cmp({lit_nm, ".alarm"}, int'(alarm), lit_alarm);
        cmp({lit_nm, ".done"},  int'(done),  lit_done);
        cmp({lit_nm, ".model_min"}, mdl.mn, lit_min);
        cmp({lit_nm, ".model_sec"}, mdl.sc, lit_sec);
        cmp({lit_nm, ".model_alarm"}, int'(mdl.alarm), lit_alarm);
      end
    end
  end

  task automatic step(input logic t, input logic s, input logic c, input logic mi, input logic si);
    sec_tick = t; btn_start = s; btn_clear = c; btn_min_inc = mi; btn_sec_inc = si;
    @(posedge mclk);
    #1;
    sec_tick = 1'b0; btn_start = 1'b0; btn_clear = 1'b0; btn_min_inc = 1'b0; btn_sec_inc = 1'b0;
  endtask

  task automatic set_lit(input string nm, input int mn, input int sc, input int rn,
                         input int al, input int dn);
    lit_nm = nm; lit_min = mn; lit_sec = sc; lit_run = rn; lit_alarm = al; lit_done = dn;
  endtask

  task automatic expect_at_negedge(input string nm, input int mn, input int sc, input int rn,
                                   input int al, input int dn);
    set_lit(nm, mn, sc, rn, al, dn);
    lit_req = 1'b1;
    @(negedge mclk);
    #1;
    lit_req = 1'b0;
  endtask

  initial begin
    #2 rst_n = 1'b0;
    @(negedge mclk);
    rst_n = 1'b1;
    chk_en = 1'b1;
    expect_at_negedge("reset", 0, 0, 0, 0, 0);

    // Preset wrap
    repeat (58) step(0, 0, 0, 0, 1);
    expect_at_negedge("sec58", 0, 58, 0, 0, 0);
    repeat (3) step(0, 0, 0, 0, 1);
    expect_at_negedge("sec_wrap", 0, 1, 0, 0, 0);
    repeat (99) step(0, 0, 0, 1, 0);
    expect_at_negedge("min99", 99, 1, 0, 0, 0);
    step(0, 0, 0, 1, 0);
    expect_at_negedge("min_wrap", 0, 1, 0, 0, 0);
    step(0, 0, 0, 1, 1);
    expect_at_negedge("both_inc", 1, 2, 0, 0, 0);

    // Countdown from 01:02
    step(0, 1, 0, 0, 0);
    expect_at_negedge("start", 1, 2, 1, 0, 0);
    step(1, 0, 0, 0, 0);
    expect_at_negedge("tick1", 1, 1, 1, 0, 0);
    step(1, 0, 0, 0, 0);
    expect_at_negedge("tick2", 1, 0, 1, 0, 0);
    step(1, 0, 0, 0, 0);
    expect_at_negedge("borrow", 0, 59, 1, 0, 0);
    step(0, 0, 0, 1, 1);
    expect_at_negedge("inc_in_run", 0, 59, 1, 0, 0);
    step(0, 0, 1, 0, 0);
    expect_at_negedge("clear_run", 0, 0, 0, 0, 0);

    // Expiry and alarm timeout
    repeat (2) step(0, 0, 0, 0, 1);
    step(0, 1, 0, 0, 0);
    step(1, 0, 0, 0, 0);
    expect_at_negedge("exp_0001", 0, 1, 1, 0, 0);
    step(1, 0, 0, 0, 0);
    expect_at_negedge("expire", 0, 0, 0, 1, 1);
    step(0, 0, 0, 1, 1);
    expect_at_negedge("alarm_hold", 0, 0, 0, 1, 0);
    repeat (9) step(1, 0, 0, 0, 0);
    expect_at_negedge("alarm_9", 0, 0, 0, BLINK ? 0 : 1, 0);
    step(1, 0, 0, 0, 0);
    expect_at_negedge("timeout", 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0);
    expect_at_negedge("idle_tick", 0, 0, 0, 0, 0);

    // Pause with coinciding tick
    repeat (5) step(0, 0, 0, 0, 1);
    step(0, 1, 0, 0, 0);
    expect_at_negedge("run_0005", 0, 5, 1, 0, 0);
    step(1, 1, 0, 0, 0);
    expect_at_negedge("tick_pause", 0, 4, 0, 0, 0);
    repeat (3) step(1, 0, 0, 0, 0);
    expect_at_negedge("pause_hold", 0, 4, 0, 0, 0);
    step(0, 1, 0, 0, 0);
    expect_at_negedge("resume", 0, 4, 1, 0, 0);
    step(1, 0, 0, 0, 0);
    expect_at_negedge("resume_tick", 0, 3, 1, 0, 0);
    step(0, 0, 1, 0, 0);

    // Edge cases
    step(0, 1, 0, 0, 0);
    expect_at_negedge("start_zero", 0, 0, 0, 0, 0);
    step(0, 0, 1, 1, 1);
    expect_at_negedge("clear_beats_inc", 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 1);
    step(0, 1, 0, 0, 0);
    step(1, 1, 0, 0, 0);
    expect_at_negedge("alarm_beats_pause", 0, 0, 0, 1, 1);
    step(1, 0, 0, 0, 0);
    expect_at_negedge("blink_1", 0, 0, 0, BLINK ? 0 : 1, 0);
    step(1, 0, 0, 0, 0);
    expect_at_negedge("blink_2", 0, 0, 0, 1, 0);
    step(0, 1, 0, 0, 0);
    expect_at_negedge("ack", 0, 0, 0, 0, 0);

    // Asynchronous reset mid-RUN at 02:30
    repeat (2) step(0, 0, 0, 1, 0);
    repeat (30) step(0, 0, 0, 0, 1);
    step(0, 1, 0, 0, 0);
    expect_at_negedge("run_0230", 2, 30, 1, 0, 0);
    @(posedge mclk);
    #2 rst_n = 1'b0;
    #1;
    set_lit("async_reset", 0, 0, 0, 0, 0);
    lit_req = 1'b1;
    probe = 1'b1;
    #1;
    probe = 1'b0;
    lit_req = 1'b0;
    @(negedge mclk);
    #1 rst_n = 1'b1;
    step(1, 0, 0, 0, 0);
    expect_at_negedge("post_reset", 0, 0, 0, 0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
